// File: rtl/uart_pkg.sv
// Shared UART definitions: line levels, default baud divisor and TX state encoding.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after the data bits.
package uart_pkg;

  // 100 MHz system clock divided down to 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL     = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd5,
`endif
    STOP   = 3'd6
  } tx_state_e;

  // True for the states that put a timed bit on the line and need the baud counter
  function automatic logic is_bit_state(input tx_state_e s);
    logic r;
    case (s)
      START, DATA, STOP: r = 1'b1;
`ifdef UART_TX_PARITY_EN
      PARITY:            r = 1'b1;
`endif
      default:           r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud-rate tick generator: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last clock of each bit period. Shared between the UART TX and the future RX block.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign bit_end = en && (count == CNT_LAST);

  // Bit-period counter: wraps at the terminal value so it never overflows its width
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (en) begin
      if (bit_end) begin
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one byte at a time from the sync FIFO,
// sends it as 8N1 (LSB first) and pulses pkt_done when a packet's last byte has left.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_dout_last,
  output logic                  tx,
  output logic                  busy,
  output logic                  pkt_done
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic                  last_q, last_d;
  logic                  tx_q, tx_d;
  logic                  baud_en;
  logic                  baud_clr;
  logic                  bit_end;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  // The counter only runs while a bit is on the line and is held at zero otherwise,
  // so every START begins with a full bit period
  assign baud_en  = is_bit_state(state_q);
  assign baud_clr = !baud_en;
  assign tx       = tx_q;

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (baud_en),
    .clr     (baud_clr),
    .bit_end (bit_end)
  );

  // State, shift register and registered line level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      last_q    <= 1'b0;
      tx_q      <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      last_q    <= last_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next-state and next line level; tx_d is the level for the state being entered
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    last_d     = last_q;
    tx_d       = tx_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    fifo_rd_en = 1'b0;
    pkt_done   = 1'b0;
    busy       = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        tx_d = UART_IDLE_LEVEL;
        if (tx_en && !fifo_empty) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        fifo_rd_en = 1'b1;
        state_d    = LOAD;
      end

      LOAD: begin
        // The FIFO only holds dout_last for this one cycle, so capture everything now
        shift_d   = fifo_dout;
        last_d    = fifo_dout_last;
`ifdef UART_TX_PARITY_EN
        parity_d  = ^fifo_dout;
`endif
        bit_idx_d = '0;
        tx_d      = START_LEVEL;
        state_d   = START;
      end

      START: begin
        if (bit_end) begin
          tx_d      = shift_q[0];
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end

      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == IDX_LAST) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            tx_d      = parity_q;
            state_d   = PARITY;
`else
            tx_d      = UART_IDLE_LEVEL;
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            tx_d      = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          tx_d    = UART_IDLE_LEVEL;
          state_d = STOP;
        end
      end
`endif

      STOP: begin
        if (bit_end) begin
          pkt_done = last_q;
          tx_d     = UART_IDLE_LEVEL;
          state_d  = (tx_en && !fifo_empty) ? FETCH : IDLE;
        end
      end

      default: begin
        tx_d    = UART_IDLE_LEVEL;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer of the sync FIFO: drains bytes from the FIFO read port and serializes them onto a UART TX line.
- Frame format: 8N1 by default, LSB first.
- Carries the FIFO's per-byte last flag through and pulses pkt_done when the last byte of a packet has fully left the line.
- Sits between the AXIS-fed FIFO and the chip-level UART TX pin.

Parameters:
- DATA_WIDTH, 8, byte width; must match the FIFO WIDTH.
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- tx_en  in  1  permit fetching new bytes; does not abort a frame in flight.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  one-cycle pop strobe to FIFO.
- fifo_dout  in  DATA_WIDTH  FIFO read data; valid the cycle after fifo_rd_en.
- fifo_dout_last  in  1  FIFO last flag; valid only the cycle after fifo_rd_en.
- tx  out  1  serial line; idle high; registered.
- busy  out  1  high in every state except IDLE.
- pkt_done  out  1  one-cycle pulse at the end of a stop bit whose byte had last=1.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE, tx=1, fifo_rd_en=0, busy=0, pkt_done=0, baud counter=0, bit index=0, shift reg=0, last_q=0.
- States: IDLE, FETCH, LOAD, START, DATA, [PARITY], STOP.
- IDLE: if tx_en && !fifo_empty, go to FETCH.
- FETCH: fifo_rd_en=1 for exactly this one cycle (decoded from state); then go to LOAD.
- LOAD:
  - Capture fifo_dout into the shift reg and fifo_dout_last into last_q.
  - The capture must happen in this cycle: the FIFO self-clears dout_last one cycle later.
  - tx is driven 0 at the edge leaving LOAD; go to START.
- Baud counter: counts 0..CLKS_PER_BIT-1 in START/DATA/PARITY/STOP, wraps to 0; bit_end = (count == CLKS_PER_BIT-1).
- START: tx=0; on bit_end go to DATA with bit index=0.
- DATA:
  - tx = shift_reg[0].
  - On bit_end: shift right and increment the index.
  - After index DATA_WIDTH-1, go to PARITY (if enabled) else STOP.
- STOP: tx=1. On bit_end:
  - pkt_done=1 for that one cycle if last_q.
  - If tx_en && !fifo_empty, go directly to FETCH; else go to IDLE.
- Latency: the first tx falling edge occurs 3 clk edges after IDLE samples tx_en && !fifo_empty.
- Frame length: each frame occupies exactly (2 + DATA_WIDTH [+1]) * CLKS_PER_BIT cycles of tx.
- Back-to-back: the inter-frame gap is exactly 2 extra idle-high cycles (FETCH + LOAD).
- Boundary conditions:
  - fifo_empty is never sampled outside IDLE/STOP-end, so a pop is never issued on empty.
  - tx_en dropping mid-frame: the current frame completes; no further fetch.
  - Reset mid-frame: tx=1 on the next edge and the byte is dropped. The FIFO is not re-read, so that byte is lost by design.
  - fifo_empty rising while in LOAD is irrelevant: data was already popped.
  - Bit index and counter widths: $clog2(DATA_WIDTH) and $clog2(CLKS_PER_BIT); no overflow past terminal values.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA; tx = even parity (XOR of all data bits) for CLKS_PER_BIT cycles.
  - Parity is computed at LOAD from fifo_dout.
- Undefined:
  - PARITY state, parity register and logic are absent; DATA goes directly to STOP.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams (IDLE..STOP, 3-bit);
  - UART_IDLE_LEVEL=1'b1, START_LEVEL=1'b0;
  - default CLKS_PER_BIT.
- Sub-module uart_baud_gen:
  - counter with enable and sync clear; outputs bit_end.
  - Reused by the future RX block.

Test Plan (CLKS_PER_BIT=4, FIFO instantiated in bench):
- Single byte 0xA5, last=0, tx_en=1 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; fifo_rd_en pulses once; busy high 42 cycles (FETCH+LOAD + 40); pkt_done never asserts.
- Bytes 0x01, 0x80(last=1) pushed together -> two frames separated by exactly 2 extra idle-high cycles; pkt_done pulses once, on the final cycle of the second stop bit; FIFO empty afterwards.
- tx_en=0 with FIFO holding 0x3C -> tx stays 1, fifo_rd_en stays 0; raise tx_en -> frame starts 3 edges later.
- tx_en dropped mid-DATA with 2 bytes queued -> current frame completes, state returns to IDLE, one byte remains in the FIFO.
- rst_n=0 for 1 cycle during DATA bit 3 -> tx=1 next edge, busy=0, pkt_done=0; no spurious fifo_rd_en.
- UART_TX_PARITY_EN defined, byte 0x07 -> parity bit 1 between bit 7 and stop; frame length 44 cycles.
